// File: rtl/digit_pkg.sv
// Shared definitions for the digit argmax sequencer: FSM encoding, class count, slot map.
// No logic, no latency, no backpressure.
package digit_pkg;

    localparam int         NUM_CLASSES   = 10;
    localparam logic [3:0] DIGIT_INVALID = 4'hF;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    // The engine reports digit = 9 - slot, so digit k lives in slot 9 - k.
    function automatic logic [3:0] slot_of(input logic [3:0] k);
        return 4'(NUM_CLASSES - 1) - k;
    endfunction

endpackage

// File: rtl/digit_score_packer.sv
// Packs a 10-beat score frame into the engine bus and checks framing.
// Single-cycle frame_done/frame_err flags on the accepting beat; caller gates beat_vld_i with its ready.
module digit_score_packer
    import digit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         beat_vld_i,
    input  logic [WIDTH-1:0]             beat_dat_i,
    input  logic                         beat_last_i,
    output logic                         frame_done_o,
    output logic                         frame_err_o,
    output logic [3:0]                   index_o,
    output logic [NUM_CLASSES*WIDTH-1:0] nums_o
);

    logic [3:0]                   index_q, index_d;
    logic [NUM_CLASSES*WIDTH-1:0] nums_q;
    logic                         is_end;

    always_comb begin
        is_end       = (index_q == 4'(NUM_CLASSES - 1));
        frame_done_o = beat_vld_i & is_end & beat_last_i;
        // s_last on the wrong beat, or no s_last on the tenth beat
        frame_err_o  = beat_vld_i & (is_end ^ beat_last_i);
        index_d      = index_q;
        if (beat_vld_i) begin
            index_d = (is_end | beat_last_i) ? 4'd0 : 4'(index_q + 4'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            index_q <= 4'd0;
            nums_q  <= '0;
        end else begin
            index_q <= index_d;
            if (beat_vld_i) begin
                nums_q[int'(slot_of(index_q))*WIDTH +: WIDTH] <= beat_dat_i;
            end
        end
    end

    assign index_o = index_q;
    assign nums_o  = nums_q;

endmodule

// File: rtl/digit_argmax_ctrl.sv
// Sequencer around the 10-way argmax engine; optional done watchdog under DIGIT_ARGMAX_TIMEOUT_EN.
// Last beat to r_valid is 6 cycles with a 4-cycle engine; s_ready low from LAUNCH until the result is taken.
module digit_argmax_ctrl #(
    parameter int WIDTH          = 32,
    parameter int NUM_CLASSES    = 10,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [WIDTH-1:0]             s_data,
    input  logic                         s_last,
    output logic                         eng_start,
    output logic [NUM_CLASSES*WIDTH-1:0] eng_nums,
    input  logic                         eng_done,
    input  logic [3:0]                   eng_digit,
    output logic                         r_valid,
    input  logic                         r_ready,
    output logic [3:0]                   r_digit,
    output logic                         frame_err,
    output logic                         busy
);
    import digit_pkg::*;

    if (NUM_CLASSES != 10 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("digit_argmax_ctrl: NUM_CLASSES must be 10 and TIMEOUT_CYCLES at least 1");
    end

    state_t     state_q, state_d;
    logic       r_valid_q, r_valid_d;
    logic [3:0] r_digit_q, r_digit_d;
    logic       frame_err_q, frame_err_d;
    logic       beat_vld, frame_done, pack_err, timeout_hit;
    logic [3:0] pack_index;

    assign beat_vld = s_valid & s_ready;

    digit_score_packer #(.WIDTH(WIDTH)) u_packer (
        .clk          (clk),
        .reset        (reset),
        .beat_vld_i   (beat_vld),
        .beat_dat_i   (s_data),
        .beat_last_i  (s_last),
        .frame_done_o (frame_done),
        .frame_err_o  (pack_err),
        .index_o      (pack_index),
        .nums_o       (eng_nums)
    );

`ifdef DIGIT_ARGMAX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    // Zero outside WAIT, so it is already clear on entry.
    always_ff @(posedge clk) begin
        if (reset || state_q != ST_WAIT) cnt_q <= '0;
        else                             cnt_q <= CNT_W'(cnt_q + 1'b1);
    end

    assign timeout_hit = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        r_valid_d   = r_valid_q;
        r_digit_d   = r_digit_q;
        frame_err_d = pack_err;
        case (state_q)
            ST_COLLECT: if (frame_done) state_d = ST_LAUNCH;
            ST_LAUNCH:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (eng_done) begin
                    r_digit_d = eng_digit;
                    r_valid_d = 1'b1;
                    state_d   = ST_HOLD;
                end else if (timeout_hit) begin
                    r_digit_d   = DIGIT_INVALID;
                    r_valid_d   = 1'b1;
                    frame_err_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_ready) begin
                    r_valid_d = 1'b0;
                    state_d   = ST_COLLECT;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_COLLECT;
            r_valid_q   <= 1'b0;
            r_digit_q   <= 4'd0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_valid_q   <= r_valid_d;
            r_digit_q   <= r_digit_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign s_ready   = (state_q == ST_COLLECT);
    assign eng_start = (state_q == ST_LAUNCH);
    assign r_valid   = r_valid_q;
    assign r_digit   = r_digit_q;
    assign frame_err = frame_err_q;
    assign busy      = !((state_q == ST_COLLECT) && (pack_index == 4'd0));

endmodule

// File: tb/tb_digit_argmax_ctrl.sv
// Self-checking bench for digit_argmax_ctrl: timeline model of the sequencer plus an engine stub.
module tb_digit_argmax_ctrl;
    localparam int W  = 32;
    localparam int NC = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_valid = 1'b0, s_last = 1'b0, eng_done = 1'b0, r_ready = 1'b0;
    logic [W-1:0]  s_data = '0;
    logic [3:0]    eng_digit = 4'd0;
    logic          s_ready, eng_start, r_valid, frame_err, busy;
    logic [3:0]    r_digit;
    logic [NC*W-1:0] eng_nums;

    always #5 clk = ~clk;

    digit_argmax_ctrl #(.WIDTH(W), .NUM_CLASSES(NC), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .eng_start(eng_start), .eng_nums(eng_nums), .eng_done(eng_done),
        .eng_digit(eng_digit), .r_valid(r_valid), .r_ready(r_ready), .r_digit(r_digit),
        .frame_err(frame_err), .busy(busy)
    );

    int n_tests = 0, n_fail = 0, ncyc = 0;
    always @(posedge clk) ncyc++;

    task automatic chk(input string nm, input logic [NC*W-1:0] act, input logic [NC*W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, ncyc);
        end
    endtask

    // Reference: highest digit among the maxima.
    function automatic int ref_argmax(input logic [W-1:0] sc[NC]);
        int best = 0;
        for (int d = 1; d < NC; d++) if (sc[d] >= sc[best]) best = d;
        return best;
    endfunction

    // Engine stub: scans slots low to high, first strict max wins, reports 9 - slot.
    function automatic logic [3:0] stub_pick(input logic [NC*W-1:0] nums);
        int bs = 0;
        for (int s = 1; s < NC; s++) if (nums[s*W +: W] > nums[bs*W +: W]) bs = s;
        return 4'(NC - 1 - bs);
    endfunction

    int              stub_pend = 0;
    bit              stub_dead = 1'b0;
    logic [NC*W-1:0] stub_nums;
    always @(posedge clk) begin
        #1;
        eng_done = 1'b0;
        if (stub_pend > 0) begin
            stub_pend--;
            if (stub_pend == 0) begin
                eng_done  = 1'b1;
                eng_digit = stub_pick(stub_nums);
            end
        end
        if (eng_start && !stub_dead) begin
            stub_pend = 4;
            stub_nums = eng_nums;
        end
    end

    // Timeline model: expectations keyed on the cycle a frame's last beat was accepted.
    logic [W-1:0]    m_scores[NC];
    logic [NC*W-1:0] m_packed;
    int              m_count = 0, m_start_cyc = -1, m_result_cyc = -1, m_err_cyc = -1;
    bit              m_ready = 1'b1, m_rv = 1'b0, m_err_pend = 1'b0, chk_en = 1'b0;
    logic [3:0]      m_rd = 4'd0, m_pend_digit = 4'd0;
    int              n_start_seen = 0, n_err_seen = 0;

    always @(negedge clk) begin
        bit exp_start, exp_err;
        if (chk_en) begin
            exp_start = (ncyc == m_start_cyc);
            exp_err   = m_err_pend || (ncyc == m_err_cyc);
            if (ncyc == m_result_cyc) begin
                m_rv = 1'b1;
                m_rd = m_pend_digit;
            end
            chk("s_ready", s_ready, m_ready);
            chk("eng_start", eng_start, exp_start);
            chk("r_valid", r_valid, m_rv);
            chk("r_digit", r_digit, m_rd);
            chk("frame_err", frame_err, exp_err);
            chk("busy", busy, !m_ready || (m_count != 0));
            if (exp_start) chk("eng_nums", eng_nums, m_packed);
            if (eng_start) n_start_seen++;
            if (frame_err) n_err_seen++;
        end
        m_err_pend = 1'b0;
        if (reset) begin
            m_ready = 1'b1; m_rv = 1'b0; m_rd = 4'd0; m_count = 0;
            m_start_cyc = -1; m_result_cyc = -1; m_err_cyc = -1;
            chk_en = 1'b1;
        end else begin
            if (s_valid && m_ready) begin
                m_scores[m_count] = s_data;
                if (s_last && m_count == NC - 1) begin
                    m_ready      = 1'b0;
                    m_start_cyc  = ncyc + 1;
                    m_pend_digit = 4'(ref_argmax(m_scores));
                    for (int k = 0; k < NC; k++) m_packed[(NC - 1 - k)*W +: W] = m_scores[k];
                    if (stub_dead) begin
                        m_result_cyc = ncyc + 18;
                        m_err_cyc    = ncyc + 18;
                        m_pend_digit = 4'hF;
                    end else begin
                        m_result_cyc = ncyc + 6;
                    end
                    m_count = 0;
                end else if (s_last || m_count == NC - 1) begin
                    m_err_pend = 1'b1;
                    m_count    = 0;
                end else begin
                    m_count++;
                end
            end
            if (m_rv && r_ready) begin
                m_rv    = 1'b0;
                m_ready = 1'b1;
            end
        end
    end

    logic [W-1:0] fr[NC];

    task automatic send_beats(input int nbeats, input int last_at, input bit gaps);
        for (int k = 0; k < nbeats; k++) begin
            int waitc = 0;
            if (gaps && k > 0 && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
            s_valid = 1'b1; s_data = fr[k]; s_last = (k == last_at);
            @(negedge clk);
            while (!s_ready && waitc < 50) begin waitc++; @(negedge clk); end
            if (!s_ready) begin
                n_tests++; n_fail++;
                $display("FAIL beat_accept: s_ready = 0 after 50 cycles, required 1");
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic take_result(input int delay, output logic [3:0] dig);
        int waitc = 0;
        @(negedge clk);
        while (!r_valid && waitc < 60) begin waitc++; @(negedge clk); end
        if (!r_valid) begin
            n_tests++; n_fail++;
            $display("FAIL result_wait: r_valid = 0 after 60 cycles, required 1");
        end
        dig = r_digit;
        repeat (delay) @(negedge clk);
        @(posedge clk); #1; r_ready = 1'b1;
        @(posedge clk); #1; r_ready = 1'b0;
    endtask

    initial begin
        logic [3:0] dig;
        int lc, e0, s0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", s_ready, 1); chk("rst_r_valid", r_valid, 0);
        chk("rst_busy", busy, 0);       chk("rst_start", eng_start, 0);
        chk("rst_digit", r_digit, 0);   chk("rst_nums", eng_nums, 0);

        // Single clear winner, exact latency, then a long hold.
        fr = '{32'd5, 32'd1, 32'd2, 32'd3, 32'd4, 32'd900, 32'd6, 32'd7, 32'd8, 32'd9};
        @(posedge clk); #1;
        send_beats(10, 9, 1'b0);
        @(negedge clk);
        chk("t1_start", eng_start, 1);
        chk("t1_slot4", eng_nums[4*W +: W], 900);
        repeat (4) @(negedge clk);
        chk("t1_rv_early", r_valid, 0);
        @(negedge clk);
        chk("t1_rv", r_valid, 1); chk("t1_digit", r_digit, 5);
        repeat (20) begin
            @(negedge clk);
            chk("t2_hold_rv", r_valid, 1); chk("t2_hold_digit", r_digit, 5);
            chk("t2_hold_ready", s_ready, 0);
        end
        @(posedge clk); #1 r_ready = 1'b1;
        @(posedge clk); #1 r_ready = 1'b0;
        @(negedge clk);
        chk("t2_ready_again", s_ready, 1); chk("t2_rv_clear", r_valid, 0);

        // Tie between digits 2 and 7.
        for (int k = 0; k < NC; k++) fr[k] = '0;
        fr[2] = 32'd100; fr[7] = 32'd100;
        @(posedge clk); #1;
        send_beats(10, 9, 1'b1);
        take_result(0, dig);
        chk("t3_tie", dig, 7);

        // Early s_last, then a clean frame.
        e0 = n_err_seen; s0 = n_start_seen;
        for (int k = 0; k < NC; k++) fr[k] = $urandom;
        send_beats(5, 4, 1'b0);
        repeat (3) @(negedge clk);
        chk("t4_err_pulses", n_err_seen - e0, 1);
        chk("t4_no_start", n_start_seen - s0, 0);
        fr = '{32'd1, 32'd2, 32'd3, 32'd77, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
        @(posedge clk); #1;
        send_beats(10, 9, 1'b0);
        take_result(1, dig);
        chk("t4_digit", dig, 3);

        // Reset two cycles after eng_start; the stub's late done must be ignored.
        for (int k = 0; k < NC; k++) fr[k] = $urandom;
        send_beats(10, 9, 1'b0);
        lc = 0;
        @(negedge clk);
        while (!eng_start && lc < 10) begin lc++; @(negedge clk); end
        chk("t5_start_seen", eng_start, 1);
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("t5_rv", r_valid, 0); chk("t5_ready", s_ready, 1); chk("t5_busy", busy, 0);
        repeat (4) @(negedge clk);
        chk("t5_late_done", r_valid, 0);

        // Randomized mix of good and malformed frames.
        for (int i = 0; i < 40; i++) begin
            int kind;
            kind = $urandom_range(0, 5);
            for (int k = 0; k < NC; k++) fr[k] = $urandom_range(0, 1) ? $urandom : W'($urandom_range(0, 3));
            @(posedge clk); #1;
            if (kind == 0) begin
                int la;
                la = $urandom_range(0, 8);
                send_beats(la + 1, la, 1'b1);
            end else if (kind == 1) begin
                send_beats(10, -1, 1'b1);
            end else begin
                send_beats(10, 9, 1'b1);
                take_result($urandom_range(0, 4), dig);
                chk("rand_digit", dig, ref_argmax(fr));
            end
        end

`ifdef DIGIT_ARGMAX_TIMEOUT_EN
        stub_dead = 1'b1;
        for (int k = 0; k < NC; k++) fr[k] = $urandom;
        @(posedge clk); #1;
        send_beats(10, 9, 1'b0);
        take_result(2, dig);
        chk("to_digit", dig, 4'hF);
        stub_dead = 1'b0;
`endif

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at 1 ms, required to finish");
        $fatal(1, "watchdog");
    end

endmodule
